pipelined_barrel_shifter: RTL and testbench



---
 rtl/bshift_pkg.sv | 14 +
 rtl/bshift_level.sv | 42 ++++
 rtl/pipelined_barrel_shifter.sv | 85 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bshift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Optional feature macro: PIPELINED_BARREL_SHIFTER_SRA_EN (arithmetic right shift).
package bshift_pkg;

  // Operation codes; values 5-7 are not listed and pass the operand through.
  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_SRA = 3'd4
  } op_e;

endpackage

// File: rtl/bshift_level.sv
// One combinational shift level: moves the word by SHIFT bit positions when
// enabled, otherwise passes it through.
// Optional feature macro: PIPELINED_BARREL_SHIFTER_SRA_EN (sign fill for op 4).
module bshift_level
  import bshift_pkg::*;
#(
  parameter int N     = 16,
  parameter int SHIFT = 1
) (
  input  logic [N-1:0] data,
  input  logic         enable,
  input  op_e          op,
  input  logic         sign,
  output logic [N-1:0] result
);

`ifndef PIPELINED_BARREL_SHIFTER_SRA_EN
  // Without sign fill the sign bit has no consumer in this level.
  logic unused_sign;
  assign unused_sign = sign;
`endif

  // Select the shifted/rotated form of the word for this level.
  always_comb begin
    result = data;
    if (enable) begin
      case (op)
        OP_ROL:  result = {data[N-SHIFT-1:0], data[N-1:N-SHIFT]};
        OP_ROR:  result = {data[SHIFT-1:0], data[N-1:SHIFT]};
        OP_SLL:  result = {data[N-SHIFT-1:0], {SHIFT{1'b0}}};
        OP_SRL:  result = {{SHIFT{1'b0}}, data[N-1:SHIFT]};
`ifdef PIPELINED_BARREL_SHIFTER_SRA_EN
        OP_SRA:  result = {{SHIFT{sign}}, data[N-1:SHIFT]};
`else
        OP_SRA:  result = {{SHIFT{1'b0}}, data[N-1:SHIFT]};
`endif
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator: one register stage per shift level, so a
// word accepted at edge E is presented after edge E+L-1. A single global stall
// (advance) freezes every stage while a result waits for the consumer.
// Optional feature macro: PIPELINED_BARREL_SHIFTER_SRA_EN (arithmetic right shift).
module pipelined_barrel_shifter
  import bshift_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_zero
);

  localparam int L = $clog2(N);

  // The full amount travels with the word; each level consumes its own bit.
  // zero is only meaningful in the last stage, where it drives out_zero.
  typedef struct packed {
    logic         valid;
    logic [N-1:0] data;
    logic [L-1:0] amt;
    op_e          op;
    logic         sign;
    logic         zero;
  } stage_t;

  stage_t stage_q [L];
  stage_t stage_d [L];
  logic   advance;

  assign advance   = !stage_q[L-1].valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = stage_q[L-1].valid;
  assign out_data  = stage_q[L-1].data;
  assign out_zero  = stage_q[L-1].zero;

  for (genvar i = 0; i < L; i++) begin : g_level
    logic [N-1:0] shifted;

    if (i == 0) begin : g_first
      bshift_level #(.N(N), .SHIFT(1 << i)) u_level (
        .data   (in_data),
        .enable (in_amt[0]),
        .op     (op_e'(in_op)),
        .sign   (in_data[N-1]),
        .result (shifted)
      );
      assign stage_d[i] = '{valid: in_valid, data: shifted, amt: in_amt,
                            op: op_e'(in_op), sign: in_data[N-1],
                            zero: (shifted == '0)};
    end else begin : g_rest
      bshift_level #(.N(N), .SHIFT(1 << i)) u_level (
        .data   (stage_q[i-1].data),
        .enable (stage_q[i-1].amt[i]),
        .op     (stage_q[i-1].op),
        .sign   (stage_q[i-1].sign),
        .result (shifted)
      );
      // Zero flag is formed from the value entering the register so that it
      // lands in the final stage together with out_data.
      assign stage_d[i] = '{valid: stage_q[i-1].valid, data: shifted,
                            amt: stage_q[i-1].amt, op: stage_q[i-1].op,
                            sign: stage_q[i-1].sign, zero: (shifted == '0)};
    end
  end

  // All stages load together on advance and hold together on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) stage_q[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < L; i++) stage_q[i] <= stage_d[i];
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at N=16 and N=10.
module tb_pipelined_barrel_shifter;

  localparam logic [2:0] ROL = 3'd0, ROR = 3'd1, SLL = 3'd2, SRL = 3'd3, SRA = 3'd4;

`ifdef PIPELINED_BARREL_SHIFTER_SRA_EN
  localparam logic [15:0] SRA_8000_15 = 16'hFFFF;
`else
  localparam logic [15:0] SRA_8000_15 = 16'h0001;
`endif

  logic clk = 1'b0;
  logic reset_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_amt;
  logic [2:0]  in_op;

  logic       t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_zero;
  logic [9:0] t_in_data, t_out_data;
  logic [3:0] t_in_amt;
  logic [2:0] t_in_op;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        zero;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.N(16)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  pipelined_barrel_shifter #(.N(10)) dut10 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
    .in_amt(t_in_amt), .in_op(t_in_op),
    .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_data(t_out_data), .out_zero(t_out_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Present one word to dut16 and hold it until accepted.
  task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a,
                      input logic [15:0] e, input bit expect_it);
    bit ok = 0;
    in_op = op; in_data = d; in_amt = a; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_in_ready", {31'd0, in_ready}, 32'd1);
    else if (expect_it) exp_q.push_back('{data: e, zero: (e == 16'h0)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", exp_q.size(), 32'd0);
    align();
  endtask

  task automatic run10(input string tag, input logic [2:0] op, input logic [9:0] d,
                       input logic [3:0] a, input logic [9:0] e);
    bit ok = 0;
    bit got = 0;
    t_in_op = op; t_in_data = d; t_in_amt = a; t_in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (t_in_ready) begin ok = 1; break; end
    end
    if (!ok) check({tag, "_in_ready"}, {31'd0, t_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    t_in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (t_out_valid) begin got = 1; break; end
    end
    check({tag, "_valid"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, "_data"}, {22'd0, t_out_data}, {22'd0, e});
      check({tag, "_zero"}, {31'd0, t_out_zero}, {31'd0, (e == 10'h0)});
    end
    align();
  endtask

  // Scoreboard: every word leaving dut16 must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("stray_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, e.data});
        check("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    t_in_valid = 1'b0; t_in_data = '0; t_in_amt = '0; t_in_op = '0; t_out_ready = 1'b1;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst10_out_valid", {31'd0, t_out_valid}, 32'd0);
    #20;
    align();
    reset_n = 1'b1;
    align();

    // Latency: visible after the fourth edge counting the accepting edge.
    send(ROL, 16'h8001, 4'd1, 16'h0003, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    align();

    send(ROR, 16'h0003, 4'd1, 16'h8001, 1);
    send(SRA, 16'h8000, 4'd15, SRA_8000_15, 1);
    send(SRL, 16'h8000, 4'd15, 16'h0001, 1);
    drain();

    // Four back-to-back words leave on four consecutive cycles.
    send(SLL, 16'h00FF, 4'd8, 16'hFF00, 1);
    send(SLL, 16'h0001, 4'd15, 16'h8000, 1);
    send(SRL, 16'h0001, 4'd1, 16'h0000, 1);
    send(ROR, 16'h1234, 4'd4, 16'h4123, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("burst_v0", {31'd0, out_valid}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("burst_vn", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    check("burst_end", {31'd0, out_valid}, 32'd0);
    drain();

    // Back-pressure with a full pipeline.
    out_ready = 1'b0;
    send(ROL, 16'h0F00, 4'd4, 16'hF000, 1);
    send(ROR, 16'h0F00, 4'd4, 16'h00F0, 1);
    send(SLL, 16'hABCD, 4'd4, 16'hBCD0, 1);
    send(SRL, 16'hABCD, 4'd4, 16'h0ABC, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {16'd0, out_data}, 32'h0000F000);
    end
    align();
    out_ready = 1'b1;
    drain();

    // Reset with three words in flight; none may ever emerge.
    send(ROL, 16'h1111, 4'd1, 16'h2222, 0);
    send(SLL, 16'h0101, 4'd2, 16'h0404, 0);
    send(SRL, 16'h8080, 4'd3, 16'h1010, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_data", {16'd0, out_data}, 32'd0);
    align();
    align();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    align();
    send(SRA, 16'h4000, 4'd2, 16'h1000, 1);
    drain();

    // N=10: non-power-of-two width.
    run10("n10_rol12", ROL, 10'h201, 4'd12, 10'h006);
    run10("n10_ror12", ROR, 10'h006, 4'd12, 10'h201);
    run10("n10_sll12", SLL, 10'h3FF, 4'd12, 10'h000);
    run10("n10_srl9", SRL, 10'h3FF, 4'd9, 10'h001);
    run10("n10_op6", 3'd6, 10'h155, 4'd3, 10'h155);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
